cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 105 ++++++++++
 tb/tb_cache_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Round-robin arbiter that shares one L2 port between an I-cache and a D-cache.
// The L2 command comes only from registers latched on the grant edge, so requester changes mid-service are ignored.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [1:0]            state;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  write_q;

    logic i_req;
    logic d_req;
    logic serving;
    logic pick_d;

    assign i_req   = i_read;
    assign d_req   = d_read | d_write;
    assign serving = (state == SERVE_I) || (state == SERVE_D);

    // On a tie the requester that was not served last wins.
    assign pick_d  = d_req && (!i_req || (last_grant == GRANT_I));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state   <= SERVE_D;
                        addr_q  <= d_address;
                        wdata_q <= d_wdata;
                        write_q <= d_write;
                    end else if (i_req) begin
                        state   <= SERVE_I;
                        addr_q  <= i_address;
                        wdata_q <= '0;
                        write_q <= 1'b0;
                    end
                end
                SERVE_I: begin
                    if (l2_resp) begin
                        state      <= IDLE;
                        last_grant <= GRANT_I;
                    end
                end
                SERVE_D: begin
                    if (l2_resp) begin
                        state      <= IDLE;
                        last_grant <= GRANT_D;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign l2_read    = serving && !write_q;
    assign l2_write   = serving && write_q;
    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;

    // Read data is broadcast unconditionally; only the resp pulse qualifies it.
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;
    assign i_resp  = (state == SERVE_I) && l2_resp;
    assign d_resp  = (state == SERVE_D) && l2_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
module tb_cache_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk;
    logic          reset;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          l2_read;
    logic          l2_write;
    logic [AW-1:0] l2_address;
    logic [LW-1:0] l2_wdata;
    logic [LW-1:0] l2_rdata;
    logic          l2_resp;

    int vectors;
    int miscompares;
    logic [3:0] flags;
    logic [3:0] exp_flags;

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign flags = {l2_read, l2_write, i_resp, d_resp};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (flags !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected %b", flags, 4'b0000);
        end
        vectors++;
        if (l2_address !== '0 || l2_wdata !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_bus: got addr %h wdata %h expected 0", l2_address, l2_wdata);
        end
        step();
        i_read = 1'b0; d_read = 1'b0; l2_resp = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL release_flags: got %b expected %b", flags, 4'b0000);
        end
    endtask

    task automatic test_i_fill();
        step();
        i_read = 1'b1;
        i_address = 16'h1230;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) step();
            if (k == 1) i_read = 1'b0;
            l2_resp  = (k == 4 || k == 5);
            l2_rdata = {16{8'hA5}};
            @(negedge clk);
            exp_flags = {(k >= 1 && k <= 4), 1'b0, (k == 4), 1'b0};
            vectors++;
            if (flags !== exp_flags) begin
                miscompares++;
                $display("[TB] FAIL ifill_flags cycle %0d: got %b expected %b", k, flags, exp_flags);
            end
            if (k >= 1 && k <= 4) begin
                vectors++;
                if (l2_address !== 16'h1230) begin
                    miscompares++;
                    $display("[TB] FAIL ifill_addr cycle %0d: got %h expected 1230", k, l2_address);
                end
            end
            if (k == 4) begin
                vectors++;
                if (i_rdata !== {16{8'hA5}}) begin
                    miscompares++;
                    $display("[TB] FAIL ifill_rdata: got %h expected %h", i_rdata, {16{8'hA5}});
                end
            end
        end
    endtask

    task automatic test_tie();
        logic owner_d;
        logic [AW-1:0] exp_addr;
        step();
        reset = 1'b1;
        l2_resp = 1'b0;
        i_read = 1'b1; d_read = 1'b1;
        i_address = 16'h1111; d_address = 16'h2222;
        step();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) step();
            l2_resp  = (c % 5 == 4);
            l2_rdata = {96'd0, 32'(c) + 32'hC0DE0000};
            owner_d  = ((c / 5) % 2 == 0);
            exp_addr = owner_d ? 16'h2222 : 16'h1111;
            exp_flags = {(c % 5 != 0), 1'b0, (c % 5 == 4) && !owner_d, (c % 5 == 4) && owner_d};
            @(negedge clk);
            vectors++;
            if (flags !== exp_flags) begin
                miscompares++;
                $display("[TB] FAIL tie_flags cycle %0d: got %b expected %b", c, flags, exp_flags);
            end
            if (c % 5 != 0) begin
                vectors++;
                if (l2_address !== exp_addr) begin
                    miscompares++;
                    $display("[TB] FAIL tie_addr cycle %0d: got %h expected %h", c, l2_address, exp_addr);
                end
            end
            if (c % 5 == 4) begin
                vectors++;
                if ((owner_d ? d_rdata : i_rdata) !== {96'd0, 32'(c) + 32'hC0DE0000}) begin
                    miscompares++;
                    $display("[TB] FAIL tie_rdata cycle %0d: got %h", c, owner_d ? d_rdata : i_rdata);
                end
            end
        end
        step();
        i_read = 1'b0; d_read = 1'b0; l2_resp = 1'b0;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL tie_end_flags: got %b expected %b", flags, 4'b0000);
        end
    endtask

    task automatic test_writeback();
        logic [LW-1:0] beef;
        beef = {96'd0, 32'hDEADBEEF};
        step();
        d_write = 1'b1; d_address = 16'h4000; d_wdata = 128'd1;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL wb_idle: got %b expected %b", flags, 4'b0000);
        end
        step();
        d_write = 1'b0; d_wdata = '1;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b0100 || l2_address !== 16'h4000 || l2_wdata !== 128'd1) begin
            miscompares++;
            $display("[TB] FAIL wb_cmd: got %b %h %h expected 0100 4000 1", flags, l2_address, l2_wdata);
        end
        step();
        l2_resp = 1'b1;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b0101) begin
            miscompares++;
            $display("[TB] FAIL wb_resp: got %b expected %b", flags, 4'b0101);
        end
        step();
        l2_resp = 1'b0;
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h4010; d_wdata = beef;
        step();
        d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b0100 || l2_wdata !== beef || l2_address !== 16'h4010) begin
            miscompares++;
            $display("[TB] FAIL rw_is_write: got %b %h %h expected 0100 4010 %h", flags, l2_address, l2_wdata, beef);
        end
        step();
        l2_resp = 1'b1;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b0101) begin
            miscompares++;
            $display("[TB] FAIL rw_resp: got %b expected %b", flags, 4'b0101);
        end
        step();
        l2_resp = 1'b0;
    endtask

    task automatic test_drop_and_hold();
        step();
        d_read = 1'b1; d_address = 16'h0800;
        step();
        d_read = 1'b0; d_address = 16'hFFF0;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b1000 || l2_address !== 16'h0800) begin
            miscompares++;
            $display("[TB] FAIL drop_c1: got %b %h expected 1000 0800", flags, l2_address);
        end
        step();
        i_read = 1'b1; i_address = 16'h3000;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b1000 || l2_address !== 16'h0800) begin
            miscompares++;
            $display("[TB] FAIL drop_c2: got %b %h expected 1000 0800", flags, l2_address);
        end
        step();
        l2_resp = 1'b1; l2_rdata = {4{32'h0BADF00D}};
        @(negedge clk);
        vectors++;
        if (flags !== 4'b1001 || d_rdata !== {4{32'h0BADF00D}}) begin
            miscompares++;
            $display("[TB] FAIL drop_resp: got %b %h expected 1001", flags, d_rdata);
        end
        step();
        l2_resp = 1'b0;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL turnaround: got %b expected %b", flags, 4'b0000);
        end
        step();
        i_read = 1'b0; l2_resp = 1'b1;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b1010 || l2_address !== 16'h3000) begin
            miscompares++;
            $display("[TB] FAIL held_i_grant: got %b %h expected 1010 3000", flags, l2_address);
        end
        step();
        l2_resp = 1'b0;
    endtask

    task automatic test_async_reset();
        step();
        i_read = 1'b1; i_address = 16'h5550;
        step();
        @(negedge clk);
        vectors++;
        if (flags !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL areset_pre: got %b expected %b", flags, 4'b1000);
        end
        #2;
        reset = 1'b1; l2_resp = 1'b1;
        #1;
        vectors++;
        if (flags !== 4'b0000 || l2_address !== '0) begin
            miscompares++;
            $display("[TB] FAIL areset_drop: got %b %h expected 0000 0000", flags, l2_address);
        end
        step();
        reset = 1'b0; l2_resp = 1'b0;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL areset_release: got %b expected %b", flags, 4'b0000);
        end
        step();
        @(negedge clk);
        vectors++;
        if (flags !== 4'b1000 || l2_address !== 16'h5550) begin
            miscompares++;
            $display("[TB] FAIL areset_regrant: got %b %h expected 1000 5550", flags, l2_address);
        end
        step();
        i_read = 1'b0; l2_resp = 1'b1;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b1010) begin
            miscompares++;
            $display("[TB] FAIL areset_resp: got %b expected %b", flags, 4'b1010);
        end
        step();
        l2_resp = 1'b0;
    endtask

    task automatic test_stray_resp();
        step();
        l2_resp = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            @(negedge clk);
            vectors++;
            if (flags !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL stray_flags cycle %0d: got %b expected %b", k, flags, 4'b0000);
            end
        end
        step();
        l2_resp = 1'b0; i_read = 1'b1; i_address = 16'h7770;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL stray_idle: got %b expected %b", flags, 4'b0000);
        end
        step();
        i_read = 1'b0;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b1000 || l2_address !== 16'h7770) begin
            miscompares++;
            $display("[TB] FAIL stray_grant: got %b %h expected 1000 7770", flags, l2_address);
        end
        step();
        l2_resp = 1'b1;
        @(negedge clk);
        vectors++;
        if (flags !== 4'b1010) begin
            miscompares++;
            $display("[TB] FAIL stray_resp: got %b expected %b", flags, 4'b1010);
        end
        step();
        l2_resp = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        i_read = 1'b1; i_address = '0;
        d_read = 1'b1; d_write = 1'b0; d_address = '0; d_wdata = '0;
        l2_resp = 1'b1; l2_rdata = '0;

        test_reset();
        test_i_fill();
        test_tie();
        test_writeback();
        test_drop_and_hold();
        test_async_reset();
        test_stray_resp();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
